// File: rtl/fpu_rr_sched.sv
// Round-robin front end for the shared add/mul/sub FPU: grants one core at a time,
// drives the operator enable for its fixed latency and returns the captured result.
module fpu_rr_sched #(
    parameter int W       = 32,
    parameter int ADD_LAT = 13,
    parameter int MUL_LAT = 10,
    parameter int SUB_LAT = 13
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req,
    input  logic [7:0]     op,
    input  logic [4*W-1:0] opa,
    input  logic [4*W-1:0] opb,
    output logic [3:0]     gnt,
    output logic [W-1:0]   fpu_a,
    output logic [W-1:0]   fpu_b,
    output logic           fpu_en_a,
    output logic           fpu_en_m,
    output logic           fpu_en_s,
    input  logic [W-1:0]   fpu_res,
    output logic           rsp_vld,
    output logic [1:0]     rsp_id,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err,
    output logic           busy,
    output logic [1:0]     dbg_state
);

    localparam int MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int MAX_LAT = (MAX_AM > SUB_LAT) ? MAX_AM : SUB_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q;
    logic [1:0]    ptr_q;
    logic [1:0]    id_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  opa_q;
    logic [W-1:0]  opb_q;
    logic          en_a_q;
    logic          en_m_q;
    logic          en_s_q;
    logic          rsp_vld_q;
    logic [1:0]    rsp_id_q;
    logic [W-1:0]  rsp_data_q;
    logic          rsp_err_q;

    logic          win_found_d;
    logic [1:0]    win_idx_d;
    logic [1:0]    win_op_d;
    logic [CW-1:0] win_cnt_d;

    // First requesting core at or after ptr_q, wrapping modulo 4.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!win_found_d && req[ptr_q + 2'(k)]) begin
                win_found_d = 1'b1;
                win_idx_d   = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        win_op_d = op[{win_idx_d, 1'b0} +: 2];
        case (win_op_d)
            OP_ADD:  win_cnt_d = CW'(ADD_LAT - 1);
            OP_MUL:  win_cnt_d = CW'(MUL_LAT - 1);
            OP_SUB:  win_cnt_d = CW'(SUB_LAT - 1);
            default: win_cnt_d = '0;
        endcase
    end

    // Gated by rst_n so no grant can be seen while reset is asserted.
    always_comb begin
        gnt = 4'b0000;
        if (rst_n && state_q == IDLE && win_found_d) begin
            gnt = 4'b0001 << win_idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            id_q       <= 2'd0;
            cnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            en_a_q     <= 1'b0;
            en_m_q     <= 1'b0;
            en_s_q     <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= 2'd0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            rsp_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        id_q  <= win_idx_d;
                        opa_q <= opa[win_idx_d*W +: W];
                        opb_q <= opb[win_idx_d*W +: W];
                        if (win_op_d == OP_ILL) begin
                            // Illegal opcode answers straight away without touching the FPU.
                            rsp_vld_q  <= 1'b1;
                            rsp_id_q   <= win_idx_d;
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                            state_q    <= RESP;
                        end else begin
                            cnt_q   <= win_cnt_d;
                            en_a_q  <= (win_op_d == OP_ADD);
                            en_m_q  <= (win_op_d == OP_MUL);
                            en_s_q  <= (win_op_d == OP_SUB);
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        en_a_q     <= 1'b0;
                        en_m_q     <= 1'b0;
                        en_s_q     <= 1'b0;
                        rsp_vld_q  <= 1'b1;
                        rsp_id_q   <= id_q;
                        rsp_data_q <= fpu_res;
                        rsp_err_q  <= 1'b0;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    ptr_q   <= id_q + 2'd1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fpu_a     = opa_q;
    assign fpu_b     = opb_q;
    assign fpu_en_a  = en_a_q;
    assign fpu_en_m  = en_m_q;
    assign fpu_en_s  = en_s_q;
    assign rsp_vld   = rsp_vld_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fpu_rr_sched.sv
// Bench for fpu_rr_sched: a stub FPU that only presents a valid result on the last
// enabled cycle, directed scenarios, and a randomized run against a cycle-level model.
// Handshake: a core raises req[i] with stable op/opa/opb and holds it until it sees
// gnt[i]; it drops req[i] from the next cycle. rsp_vld is always accepted.
module tb_fpu_rr_sched;

  localparam int W       = 32;
  localparam int ADD_LAT = 13;
  localparam int MUL_LAT = 10;
  localparam int SUB_LAT = 13;

  logic           clk;
  logic           rst_n;
  logic [3:0]     req;
  logic [7:0]     op;
  logic [4*W-1:0] opa;
  logic [4*W-1:0] opb;
  logic [3:0]     gnt;
  logic [W-1:0]   fpu_a;
  logic [W-1:0]   fpu_b;
  logic           fpu_en_a;
  logic           fpu_en_m;
  logic           fpu_en_s;
  logic [W-1:0]   fpu_res;
  logic           rsp_vld;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           busy;
  logic [1:0]     dbg_state;

  int checks;
  int failures;

  fpu_rr_sched #(.W(W), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .SUB_LAT(SUB_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .opa(opa), .opb(opb),
    .gnt(gnt), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_en_a(fpu_en_a), .fpu_en_m(fpu_en_m), .fpu_en_s(fpu_en_s),
    .fpu_res(fpu_res), .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- FPU stub ----------------
  function automatic logic [W-1:0] fpu_fn(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    if (o == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    case (o)
      2'b00:   return a + b;
      2'b01:   return a * b;
      2'b10:   return a - b;
      default: return '0;
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] o);
    case (o)
      2'b00:   return ADD_LAT;
      2'b01:   return MUL_LAT;
      2'b10:   return SUB_LAT;
      default: return 0;
    endcase
  endfunction

  int         en_run;
  logic [1:0] stub_op;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_run <= 0;
    else if (fpu_en_a || fpu_en_m || fpu_en_s) en_run <= en_run + 1;
    else en_run <= 0;
  end

  always_comb begin
    stub_op = 2'b11;
    if (fpu_en_a) stub_op = 2'b00;
    else if (fpu_en_m) stub_op = 2'b01;
    else if (fpu_en_s) stub_op = 2'b10;
    if (stub_op != 2'b11 && en_run + 1 == lat_of(stub_op)) fpu_res = fpu_fn(stub_op, fpu_a, fpu_b);
    else fpu_res = 32'hBAD00000 ^ W'(en_run);
  end

  // ---------------- drivers ----------------
  task automatic set_core(input int i, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    op[2*i +: 2] = o;
    opa[W*i +: W] = a;
    opb[W*i +: W] = b;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) set_core(i, 2'b00, $urandom, $urandom);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req = 4'b1111;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, fpu_a, fpu_b, fpu_en_a, fpu_en_m, fpu_en_s, rsp_vld, rsp_id, rsp_data, rsp_err, busy} !== '0) begin
      failures++;
      $display("FAIL reset_async: outputs=%h required all zero",
               {gnt, fpu_a, fpu_b, fpu_en_a, fpu_en_m, fpu_en_s, rsp_vld, rsp_id, rsp_data, rsp_err, busy});
    end
    @(negedge clk);
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: gnt=%b busy=%b required 0000/0", gnt, busy);
    end
    req   = 4'b0000;
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    int g_c, en_first, en_last, en_n, other_en, rsp_c, rsp_n, a_bad;
    logic [W-1:0] rd;
    logic [1:0]   rid;
    logic         rerr;
    g_c = -1; en_first = -1; en_last = -1; en_n = 0; other_en = 0; rsp_c = -1; rsp_n = 0; a_bad = 0;
    rd = '0; rid = '0; rerr = 1'b0;
    do_reset();
    set_core(0, 2'b00, 32'h3F800000, 32'h40000000);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      req = (g_c < 0) ? 4'b0001 : 4'b0000;
      #1;
      if (g_c < 0 && gnt == 4'b0001) g_c = c;
      if (fpu_en_a) begin
        en_n++;
        if (en_first < 0) en_first = c;
        en_last = c;
        if (fpu_a !== 32'h3F800000 || fpu_b !== 32'h40000000) a_bad++;
      end
      if (fpu_en_m || fpu_en_s) other_en++;
      if (rsp_vld) begin
        rsp_n++; rsp_c = c; rd = rsp_data; rid = rsp_id; rerr = rsp_err;
      end
    end
    checks++;
    if (g_c !== 0) begin failures++; $display("FAIL add_gnt: grant cycle=%0d required 0", g_c); end
    checks++;
    if (en_first !== 1 || en_last !== ADD_LAT || en_n !== ADD_LAT) begin
      failures++;
      $display("FAIL add_en: first=%0d last=%0d n=%0d required 1/%0d/%0d", en_first, en_last, en_n, ADD_LAT, ADD_LAT);
    end
    checks++;
    if (other_en !== 0 || a_bad !== 0) begin
      failures++; $display("FAIL add_side: other_en=%0d operand_bad=%0d required 0/0", other_en, a_bad);
    end
    checks++;
    if (rsp_n !== 1 || rsp_c !== ADD_LAT + 1) begin
      failures++; $display("FAIL add_rsp_time: n=%0d cycle=%0d required 1/%0d", rsp_n, rsp_c, ADD_LAT + 1);
    end
    checks++;
    if (rd !== 32'h40400000 || rid !== 2'd0 || rerr !== 1'b0) begin
      failures++; $display("FAIL add_rsp_data: data=%h id=%0d err=%b required 40400000/0/0", rd, rid, rerr);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_data !== 32'h40400000 || rsp_vld !== 1'b0) begin
      failures++; $display("FAIL add_rsp_hold: data=%h vld=%b required 40400000/0", rsp_data, rsp_vld);
    end
  endtask

  task automatic test_round_robin();
    int g_id[$], g_cyc[$], r_id[$];
    logic [W-1:0] r_data[$];
    logic [W-1:0] a[4], b[4];
    int en_m_n, other_en;
    en_m_n = 0; other_en = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a[i] = $urandom; b[i] = $urandom;
      set_core(i, 2'b01, a[i], b[i]);
    end
    for (int c = 0; c < 5 * (MUL_LAT + 2); c++) begin
      @(negedge clk);
      req = 4'b1111;
      #1;
      for (int i = 0; i < 4; i++) if (gnt[i]) begin g_id.push_back(i); g_cyc.push_back(c); end
      if (fpu_en_m) en_m_n++;
      if (fpu_en_a || fpu_en_s) other_en++;
      if (rsp_vld) begin r_id.push_back(int'(rsp_id)); r_data.push_back(rsp_data); end
    end
    @(negedge clk);
    req = 4'b0000;
    checks++;
    if (g_id.size() !== 5) begin failures++; $display("FAIL rr_count: grants=%0d required 5", g_id.size()); end
    for (int k = 0; k < g_id.size(); k++) begin
      checks++;
      if (g_id[k] !== k % 4) begin failures++; $display("FAIL rr_order: grant %0d to core %0d required %0d", k, g_id[k], k % 4); end
      if (k > 0) begin
        checks++;
        if (g_cyc[k] - g_cyc[k-1] !== MUL_LAT + 2) begin
          failures++; $display("FAIL rr_spacing: gap %0d required %0d", g_cyc[k] - g_cyc[k-1], MUL_LAT + 2);
        end
      end
    end
    checks++;
    if (en_m_n !== 5 * MUL_LAT || other_en !== 0) begin
      failures++; $display("FAIL rr_en: en_m cycles=%0d other=%0d required %0d/0", en_m_n, other_en, 5 * MUL_LAT);
    end
    checks++;
    if (r_id.size() !== 5) begin failures++; $display("FAIL rr_rsp_count: got %0d required 5", r_id.size()); end
    for (int k = 0; k < r_id.size(); k++) begin
      checks++;
      if (r_id[k] !== k % 4 || r_data[k] !== fpu_fn(2'b01, a[k % 4], b[k % 4])) begin
        failures++;
        $display("FAIL rr_rsp: rsp %0d id=%0d data=%h required %0d/%h", k, r_id[k], r_data[k], k % 4, fpu_fn(2'b01, a[k % 4], b[k % 4]));
      end
    end
  endtask

  task automatic test_pointer_skip();
    logic [3:0] pend;
    int g_id[$], g_cyc[$];
    logic added;
    pend = 4'b0010; added = 1'b0;
    do_reset();
    set_core(1, 2'b00, $urandom, $urandom);
    set_core(0, 2'b01, $urandom, $urandom);
    set_core(3, 2'b01, $urandom, $urandom);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      req = pend;
      #1;
      for (int i = 0; i < 4; i++) if (gnt[i]) begin g_id.push_back(i); g_cyc.push_back(c); pend[i] = 1'b0; end
      if (!added && g_id.size() > 0) begin pend = pend | 4'b1001; added = 1'b1; end
    end
    @(negedge clk);
    req = 4'b0000;
    checks++;
    if (g_id.size() !== 3) begin
      failures++; $display("FAIL skip_count: grants=%0d required 3", g_id.size());
    end else begin
      checks++;
      if (g_id[0] !== 1 || g_id[1] !== 3 || g_id[2] !== 0) begin
        failures++; $display("FAIL skip_order: order %0d,%0d,%0d required 1,3,0", g_id[0], g_id[1], g_id[2]);
      end
      checks++;
      if (g_cyc[1] !== ADD_LAT + 2 || g_cyc[2] !== ADD_LAT + MUL_LAT + 4) begin
        failures++; $display("FAIL skip_time: cycles %0d,%0d required %0d,%0d", g_cyc[1], g_cyc[2], ADD_LAT + 2, ADD_LAT + MUL_LAT + 4);
      end
    end
  endtask

  task automatic test_illegal();
    int en_n, rsp_n, g_n;
    en_n = 0; rsp_n = 0; g_n = 0;
    do_reset();
    set_core(2, 2'b11, $urandom, $urandom);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req = 4'b0100;
      #1;
      if (fpu_en_a || fpu_en_m || fpu_en_s) en_n++;
      if (gnt != 4'b0000) g_n++;
      if (c % 2 == 0) begin
        checks++;
        if (gnt !== 4'b0100) begin failures++; $display("FAIL ill_gnt: cycle %0d gnt=%b required 0100", c, gnt); end
      end else begin
        checks++;
        if (rsp_vld !== 1'b1 || rsp_id !== 2'd2 || rsp_err !== 1'b1 || rsp_data !== '0 || busy !== 1'b1 || gnt !== 4'b0000) begin
          failures++;
          $display("FAIL ill_rsp: cycle %0d vld=%b id=%0d err=%b data=%h busy=%b gnt=%b required 1/2/1/0/1/0000",
                   c, rsp_vld, rsp_id, rsp_err, rsp_data, busy, gnt);
        end
        rsp_n++;
      end
    end
    @(negedge clk);
    req = 4'b0000;
    checks++;
    if (en_n !== 0 || g_n !== 3) begin failures++; $display("FAIL ill_en: en cycles=%0d grants=%0d required 0/3", en_n, g_n); end
  endtask

  task automatic test_reset_mid_exec();
    int en_s_n, rsp_n;
    en_s_n = 0; rsp_n = 0;
    do_reset();
    set_core(1, 2'b10, $urandom | 32'h1, $urandom | 32'h1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req = (c == 0) ? 4'b0010 : 4'b0000;
      if (c == 5) rst_n = 1'b0;
      #1;
      if (c < 5 && fpu_en_s) en_s_n++;
    end
    checks++;
    if ({gnt, fpu_a, fpu_b, fpu_en_a, fpu_en_m, fpu_en_s, rsp_vld, rsp_id, rsp_data, rsp_err, busy} !== '0 || en_s_n !== 4) begin
      failures++;
      $display("FAIL midreset_clear: outputs=%h en_s_before=%0d required all zero/4",
               {gnt, fpu_a, fpu_b, fpu_en_a, fpu_en_m, fpu_en_s, rsp_vld, rsp_id, rsp_data, rsp_err, busy}, en_s_n);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (rsp_vld) rsp_n++;
    end
    checks++;
    if (rsp_n !== 0) begin failures++; $display("FAIL midreset_rsp: responses=%0d required 0", rsp_n); end
    for (int i = 0; i < 4; i++) set_core(i, 2'b00, $urandom, $urandom);
    @(negedge clk);
    req = 4'b1111;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL midreset_ptr: gnt=%b required 0001", gnt); end
    @(negedge clk);
    req = 4'b0000;
  endtask

  task automatic test_late_request();
    int early_g;
    early_g = 0;
    do_reset();
    set_core(0, 2'b00, $urandom, $urandom);
    set_core(1, 2'b01, $urandom, $urandom);
    for (int c = 0; c < ADD_LAT + 3; c++) begin
      @(negedge clk);
      req = (c == 0) ? 4'b0001 : ((c >= ADD_LAT + 1) ? 4'b0010 : 4'b0000);
      #1;
      if (c > 0 && c <= ADD_LAT && gnt !== 4'b0000) early_g++;
      if (c == ADD_LAT + 1) begin
        checks++;
        if (rsp_vld !== 1'b1 || gnt !== 4'b0000) begin
          failures++; $display("FAIL late_resp: rsp_vld=%b gnt=%b required 1/0000", rsp_vld, gnt);
        end
      end
      if (c == ADD_LAT + 2) begin
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL late_gnt: gnt=%b required 0010", gnt); end
      end
    end
    @(negedge clk);
    req = 4'b0000;
    checks++;
    if (early_g !== 0) begin failures++; $display("FAIL late_busy_gnt: grants during op=%0d required 0", early_g); end
  endtask

  task automatic test_random();
    int free_at, last_g, m_ptr, w, en_lo, en_hi, lat;
    logic [3:0] pend, exp_gnt;
    logic [2:0] en_mask, exp_en;
    logic [W-1:0] ea, eb, a, b;
    logic [1:0] o;
    logic exp_busy;
    int exp_cyc_q[$];
    logic [1:0] exp_id_q[$];
    logic exp_err_q[$];
    logic [W-1:0] exp_q[$];
    do_reset();
    free_at = 0; last_g = -1000; m_ptr = 0; en_lo = -1; en_hi = -2; en_mask = 3'b000;
    pend = 4'b0000; ea = '0; eb = '0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && cyc < 860 && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          set_core(i, ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), $urandom, $urandom);
        end
      end
      req = pend;
      #1;
      exp_gnt = 4'b0000; w = -1;
      if (cyc >= free_at) begin
        for (int k = 0; k < 4; k++) if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      end
      if (w >= 0) exp_gnt[w] = 1'b1;
      checks++;
      if (gnt !== exp_gnt) begin failures++; $display("FAIL rnd_gnt: cycle %0d gnt=%b required %b", cyc, gnt, exp_gnt); end
      exp_en = (cyc >= en_lo && cyc <= en_hi) ? en_mask : 3'b000;
      checks++;
      if ({fpu_en_a, fpu_en_m, fpu_en_s} !== exp_en) begin
        failures++; $display("FAIL rnd_en: cycle %0d en(a,m,s)=%b required %b", cyc, {fpu_en_a, fpu_en_m, fpu_en_s}, exp_en);
      end
      if (exp_en != 3'b000) begin
        checks++;
        if (fpu_a !== ea || fpu_b !== eb) begin
          failures++; $display("FAIL rnd_operands: cycle %0d a=%h b=%h required %h/%h", cyc, fpu_a, fpu_b, ea, eb);
        end
      end
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        checks++;
        if (rsp_vld !== 1'b1 || rsp_id !== exp_id_q[0] || rsp_err !== exp_err_q[0] || rsp_data !== exp_q[0]) begin
          failures++;
          $display("FAIL rnd_rsp: cycle %0d vld=%b id=%0d err=%b data=%h required 1/%0d/%b/%h",
                   cyc, rsp_vld, rsp_id, rsp_err, rsp_data, exp_id_q[0], exp_err_q[0], exp_q[0]);
        end
        void'(exp_cyc_q.pop_front()); void'(exp_id_q.pop_front());
        void'(exp_err_q.pop_front()); void'(exp_q.pop_front());
      end else begin
        checks++;
        if (rsp_vld !== 1'b0) begin failures++; $display("FAIL rnd_rsp_spurious: cycle %0d rsp_vld=%b required 0", cyc, rsp_vld); end
      end
      exp_busy = (cyc > last_g && cyc < free_at);
      checks++;
      if (busy !== exp_busy) begin failures++; $display("FAIL rnd_busy: cycle %0d busy=%b required %b", cyc, busy, exp_busy); end
      if (w >= 0) begin
        o = op[2*w +: 2]; a = opa[W*w +: W]; b = opb[W*w +: W];
        last_g = cyc; m_ptr = (w + 1) % 4; pend[w] = 1'b0;
        if (o == 2'b11) begin
          free_at = cyc + 2;
          exp_cyc_q.push_back(cyc + 1); exp_id_q.push_back(2'(w));
          exp_err_q.push_back(1'b1); exp_q.push_back('0);
        end else begin
          lat = lat_of(o);
          free_at = cyc + lat + 2; en_lo = cyc + 1; en_hi = cyc + lat;
          en_mask = (o == 2'b00) ? 3'b100 : ((o == 2'b01) ? 3'b010 : 3'b001);
          ea = a; eb = b;
          exp_cyc_q.push_back(cyc + lat + 1); exp_id_q.push_back(2'(w));
          exp_err_q.push_back(1'b0); exp_q.push_back(fpu_fn(o, a, b));
        end
      end
    end
    @(negedge clk);
    req = 4'b0000;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; req = 4'b0000; op = '0; opa = '0; opb = '0;
    test_reset();
    test_single_add();
    test_round_robin();
    test_pointer_skip();
    test_illegal();
    test_reset_mid_exec();
    test_late_request();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_rr_sched.md
# fpu_rr_sched

Round-robin scheduler that shares one add/mul/sub floating-point datapath among the four cores of the quad-core FPU. It accepts one request at a time, latches that core's operands and opcode, and holds the matching operator enable for that operator's fixed latency. It then captures the result and returns it with the requester's ID. It sits between the core request ports and the shared FPU operator block, and its operator-enable outputs take the place of free-running fixed-slot sequencing.

## Interface
Parameters:
- W, 32, operand/result width
- ADD_LAT, 13, add operator latency in cycles (>=1)
- MUL_LAT, 10, multiply operator latency in cycles (>=1)
- SUB_LAT, 13, subtract operator latency in cycles (>=1)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  per-core request; held high until that core's gnt
- op  input  8  per-core opcode, core i at [2i+1:2i]; 00 add, 01 mul, 10 sub, 11 illegal
- opa  input  4*W  per-core operand A, core i at [W*i+:W]
- opb  input  4*W  per-core operand B, same packing
- gnt  output  4  one-hot acceptance pulse, one cycle
- fpu_a  output  W  operand A to the FPU
- fpu_b  output  W  operand B to the FPU
- fpu_en_a  output  1  add operator enable
- fpu_en_m  output  1  mul operator enable
- fpu_en_s  output  1  sub operator enable
- fpu_res  input  W  FPU result, valid on the last EXEC cycle
- rsp_vld  output  1  response pulse, one cycle
- rsp_id  output  2  core ID of the response
- rsp_data  output  W  result (0 on error)
- rsp_err  output  1  illegal-opcode flag, valid with rsp_vld
- busy  output  1  high whenever the state is not IDLE

## Operation
- **States:** IDLE, EXEC, RESP.
- **IDLE**
  - If req != 0, select the first set bit searching from ptr upward, modulo 4.
  - gnt for the winner is combinational and asserts in this cycle.
  - On the clock edge, latch the winner's opcode, operands and ID.
  - Legal opcode: load cnt = LAT-1 for the selected operator and go to EXEC.
  - Opcode 11: set err, go to RESP, and never touch the FPU enables.
- **EXEC**
  - Exactly one fpu_en_* is high, matching the latched opcode.
  - fpu_a and fpu_b are driven from the latched operands.
  - cnt decrements each cycle.
  - When cnt == 0: capture fpu_res into rsp_data and go to RESP.
- **RESP**
  - rsp_vld = 1 for one cycle, together with rsp_id, rsp_data and rsp_err.
  - ptr <= rsp_id + 1 (2-bit wrap: 3 wraps to 0).
  - Return to IDLE.
- **Requests outside IDLE:** req is ignored in EXEC and RESP, and gnt stays 0.
- **No response back-pressure:** the consumer must always accept rsp_vld.
- **Output values:**
  - Enables are 0 outside EXEC.
  - fpu_a and fpu_b hold their last latched values.
  - rsp_data, rsp_id and rsp_err hold their values until the next RESP.
- **cnt width:** enough bits for max(LAT)-1. No overflow is possible.

## Timing
- **Reset:**
  - state=IDLE, ptr=0, cnt=0, latched operands=0, err=0.
  - gnt is 0 while rst_n is low.
  - All outputs are 0: fpu_a, fpu_b, all enables, rsp_vld, rsp_id, rsp_data, rsp_err, busy.
- **Reset mid-operation:** the in-flight operation is dropped. No rsp_vld is ever produced for it.
- **Legal op granted in cycle T:**
  - EXEC occupies T+1 .. T+LAT, with the enable high for exactly LAT cycles.
  - fpu_res is sampled at the end of T+LAT.
  - rsp_vld occurs at T+LAT+1.
  - The earliest next gnt is T+LAT+2.
- **Illegal op granted in cycle T:** rsp_vld at T+1 with rsp_err=1 and rsp_data=0. The earliest next gnt is T+2.
- **Throughput:** one operation per LAT+2 cycles.
- **Fairness:** with all four req held high, grants rotate 0,1,2,3,0,…
- **Simultaneous events:**
  - A new req that rises in the RESP cycle waits for IDLE.
  - The ptr update takes effect at that IDLE.

## Test plan
- **Single add:** after reset, req=0001, op=00, opa[0]=0x3F800000, opb[0]=0x40000000; the FPU model returns 0x40400000.
  - Expect gnt=0001 at T.
  - Expect fpu_en_a high for exactly 13 cycles (T+1..T+13).
  - Expect rsp_vld at T+14 with rsp_id=0, rsp_data=0x40400000, rsp_err=0.
- **Round-robin:** req=1111 held high, all ops mul.
  - Expect grant order 0,1,2,3,0.
  - Expect grants spaced 12 cycles apart.
  - Expect fpu_en_m high for 10 cycles per op.
- **Pointer skip:** after a grant to core 1, req=0001 | 1000.
  - Expect core 3 granted before core 0.
- **Illegal op:** core 2, op=11.
  - Expect rsp_vld one cycle after gnt with rsp_id=2, rsp_err=1, rsp_data=0.
  - Expect no fpu_en_* asserted.
- **Reset mid-EXEC:** drop rst_n on the 5th sub cycle.
  - Expect all outputs 0 immediately and no rsp_vld after release.
  - Expect the next request from core 0 to be granted first (ptr=0).
- **Late request:** req[1] rises during RESP of core 0.
  - Expect gnt=0010 in the following IDLE cycle.
  - Expect no gnt during RESP.
